// File: rtl/jump_pkg.sv
// jump_pkg: state encoding, comparator codes and width shared by the jump FU and its issue controller
package jump_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_LTU = 3'b110;
  localparam logic [2:0] CMP_GEU = 3'b111;
endpackage

// File: rtl/jump_issue_ctrl.sv
// jump_issue_ctrl: issues one jump/branch to the FU, resolves redirect and link writeback
// Optional WAIT-state watchdog enabled by defining JUMP_WATCHDOG_EN.
module jump_issue_ctrl
  import jump_pkg::*;
#(
  parameter int WDOG_CYCLES = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic            is_branch,
  input  logic            JALR,
  input  logic [2:0]      cmp_ctrl,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] PC,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            fu_EN,
  output logic            fu_JALR,
  output logic [2:0]      fu_cmp_ctrl,
  output logic [XLEN-1:0] fu_rs1_data,
  output logic [XLEN-1:0] fu_rs2_data,
  output logic [XLEN-1:0] fu_imm,
  output logic [XLEN-1:0] fu_PC,
  input  logic            fu_finish,
  input  logic            fu_cmp_res,
  input  logic [XLEN-1:0] fu_PC_jump,
  input  logic [XLEN-1:0] fu_PC_wb,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_ready,
  output logic            busy,
  output logic            wdog_err
);
  state_t state, nxt;
  logic r_branch, r_res, first, need_wb, taken, wdog_hit;
  logic [XLEN-1:0] r_jump, r_wb;
  logic [4:0] r_rd;
  assign need_wb = ~r_branch & |r_rd;
  assign taken = r_branch ? r_res : 1'b1;
  always_comb begin
    nxt = flush ? IDLE :
          state == IDLE  ? (issue_valid ? ISSUE : IDLE) :
          state == ISSUE ? WAIT :
          state == WAIT  ? (fu_finish ? RESP : wdog_hit ? IDLE : WAIT) :
          (~need_wb | wb_ready) ? IDLE : RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      first <= 1'b0;
      r_branch <= 1'b0;
      fu_JALR <= 1'b0;
      fu_cmp_ctrl <= '0;
      fu_rs1_data <= '0;
      fu_rs2_data <= '0;
      fu_imm <= '0;
      fu_PC <= '0;
      r_rd <= '0;
      r_res <= 1'b0;
      r_jump <= '0;
      r_wb <= '0;
    end else begin
      state <= nxt;
      first <= state != RESP;
      if (state == IDLE && issue_valid && !flush) begin
        r_branch <= is_branch;
        fu_JALR <= JALR;
        fu_cmp_ctrl <= cmp_ctrl;
        fu_rs1_data <= rs1_data;
        fu_rs2_data <= rs2_data;
        fu_imm <= imm;
        fu_PC <= PC;
        r_rd <= rd;
      end
      if (state == WAIT && fu_finish && !flush) begin
        r_res <= fu_cmp_res;
        r_jump <= fu_PC_jump;
        r_wb <= fu_PC_wb;
      end
    end
  end
  assign issue_ready = state == IDLE;
  assign busy = state != IDLE;
  assign fu_EN = state == ISSUE;
  assign redirect_valid = state == RESP & first & taken & ~flush;
  assign redirect_pc = {r_jump[XLEN-1:1], r_jump[0] & ~fu_JALR};
  assign wb_valid = state == RESP & need_wb & ~flush;
  assign wb_rd = r_rd;
  assign wb_data = r_wb;
`ifdef JUMP_WATCHDOG_EN
  localparam int CW = WDOG_CYCLES > 15 ? $clog2(WDOG_CYCLES + 1) : 4;
  logic [CW-1:0] cnt;
  logic err;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      err <= err | (wdog_hit & ~flush);
    end
  end
  assign wdog_hit = state == WAIT & ~fu_finish & cnt == CW'(WDOG_CYCLES - 1);
  assign wdog_err = err;
`else
  assign wdog_hit = 1'b0;
  assign wdog_err = WDOG_CYCLES < 0;
`endif
endmodule

// File: tb/tb_jump_issue_ctrl.sv
// tb_jump_issue_ctrl: directed and randomized checks of jump_issue_ctrl against a transaction-level model
module tb_jump_issue_ctrl;
  import jump_pkg::*;
  logic clk = 0, rst = 1;
  logic issue_valid = 0, issue_ready, is_branch = 0, JALR = 0, flush = 0;
  logic [2:0] cmp_ctrl = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0, imm = 0, PC = 0;
  logic [4:0] rd = 0;
  logic fu_EN, fu_JALR;
  logic [2:0] fu_cmp_ctrl;
  logic [31:0] fu_rs1_data, fu_rs2_data, fu_imm, fu_PC;
  logic fu_finish = 0, fu_cmp_res = 0;
  logic [31:0] fu_PC_jump = 0, fu_PC_wb = 0;
  logic redirect_valid, wb_valid, wb_ready = 0, busy, wdog_err;
  logic [31:0] redirect_pc, wb_data;
  logic [4:0] wb_rd;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  jump_issue_ctrl dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .is_branch(is_branch), .JALR(JALR), .cmp_ctrl(cmp_ctrl), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .PC(PC), .rd(rd), .flush(flush),
    .fu_EN(fu_EN), .fu_JALR(fu_JALR), .fu_cmp_ctrl(fu_cmp_ctrl), .fu_rs1_data(fu_rs1_data),
    .fu_rs2_data(fu_rs2_data), .fu_imm(fu_imm), .fu_PC(fu_PC), .fu_finish(fu_finish),
    .fu_cmp_res(fu_cmp_res), .fu_PC_jump(fu_PC_jump), .fu_PC_wb(fu_PC_wb),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready), .busy(busy), .wdog_err(wdog_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit ref_cmp(input logic [2:0] cc, input logic [31:0] a, input logic [31:0] b);
    case (cc)
      CMP_EQ:  return a == b;
      CMP_NE:  return a != b;
      CMP_LT:  return $signed(a) < $signed(b);
      CMP_GE:  return $signed(a) >= $signed(b);
      CMP_LTU: return a < b;
      CMP_GEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  // fl_at: 0 none, 1 ISSUE cycle, 2 WAIT cycle fl_k, 3 RESP cycle fl_k
  task automatic run_instr(input bit isb, input bit jalr, input logic [2:0] cc,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                           input logic [31:0] pc, input logic [4:0] r, input int lat,
                           input int stall, input int fl_at, input int fl_k);
    bit tk, need, done;
    logic [31:0] pj, exp_pc;
    int k;
    tk = isb ? ref_cmp(cc, a, b) : 1'b1;
    need = !isb && r != 0;
    pj = jalr ? a + im : pc + im;
    exp_pc = jalr ? pj & 32'hffff_fffe : pj;
    @(negedge clk);
    issue_valid = 1; is_branch = isb; JALR = jalr; cmp_ctrl = cc;
    rs1_data = a; rs2_data = b; imm = im; PC = pc; rd = r;
    fu_finish = 0; flush = 0; wb_ready = 0;
    #1 chk("idle_ready", issue_ready, 1);
    chk("idle_busy", busy, 0);
    tick();
    issue_valid = 0; rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; PC = $urandom; rd = 5'($urandom);
    fu_finish = 1'($urandom); fu_cmp_res = 1'($urandom); fu_PC_jump = $urandom; fu_PC_wb = $urandom;
    flush = fl_at == 1;
    #1 chk("issue_en", fu_EN, 1);
    chk("issue_ready0", issue_ready, 0);
    chk("op_rs1", fu_rs1_data, a);
    chk("op_rs2", fu_rs2_data, b);
    chk("op_imm", fu_imm, im);
    chk("op_pc", fu_PC, pc);
    chk("op_ctl", {fu_JALR, fu_cmp_ctrl}, {jalr, cc});
    if (flush) begin
      tick();
      flush = 0; fu_finish = 0;
      #1 chk("flush_issue_idle", busy, 0);
      return;
    end
    for (int w = 0; w < lat; w++) begin
      tick();
      fu_finish = w == lat - 1;
      fu_cmp_res = fu_finish ? ref_cmp(cc, a, b) : 1'($urandom);
      fu_PC_jump = fu_finish ? pj : $urandom;
      fu_PC_wb = fu_finish ? pc + 4 : $urandom;
      flush = fl_at == 2 && fl_k == w;
      #1 chk("wait_en0", fu_EN, 0);
      chk("wait_busy", busy, 1);
      chk("wait_rs1", fu_rs1_data, a);
      chk("wait_pc", fu_PC, pc);
      chk("wait_nored", redirect_valid, 0);
      chk("wait_nowb", wb_valid, 0);
      if (flush) begin
        tick();
        flush = 0; fu_finish = 0;
        #1 chk("flush_wait_idle", busy, 0);
        chk("flush_wait_nored", redirect_valid, 0);
        chk("flush_wait_nowb", wb_valid, 0);
        return;
      end
    end
    k = 0;
    done = 0;
    while (!done) begin
      tick();
      fu_finish = 1'($urandom); fu_cmp_res = 1'($urandom); fu_PC_jump = $urandom; fu_PC_wb = $urandom;
      wb_ready = k >= stall;
      flush = fl_at == 3 && fl_k == k;
      #1 chk("resp_busy", busy, 1);
      chk("resp_ready0", issue_ready, 0);
      chk("resp_en0", fu_EN, 0);
      chk("resp_redir", redirect_valid, !flush && k == 0 && tk);
      if (redirect_valid) chk("resp_pc", redirect_pc, exp_pc);
      chk("resp_wbv", wb_valid, !flush && need);
      if (wb_valid) begin
        chk("resp_wbdata", wb_data, pc + 4);
        chk("resp_wbrd", wb_rd, r);
      end
      done = flush || !need || wb_ready;
      k++;
    end
    tick();
    flush = 0; wb_ready = 0; fu_finish = 0;
    #1 chk("end_idle", busy, 0);
    chk("end_ready", issue_ready, 1);
  endtask
  initial begin
    logic [2:0] ccs [6];
    ccs = '{CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU};
    repeat (3) tick();
    rst = 0;
    #1 chk("rst_ready", issue_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", fu_EN, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_ops", fu_rs1_data | fu_rs2_data | fu_imm | fu_PC, 0);
    chk("rst_wdog", wdog_err, 0);
    run_instr(0, 0, CMP_EQ, 0, 0, 32'h20, 32'h100, 1, 1, 0, 0, 0);
    run_instr(1, 0, CMP_EQ, 5, 5, -32'sd8, 32'h40, 3, 1, 0, 0, 0);
    run_instr(0, 1, CMP_EQ, 32'h203, 0, 0, 32'h80, 0, 1, 0, 0, 0);
    run_instr(0, 1, CMP_EQ, 32'h203, 0, 0, 32'h80, 7, 2, 0, 0, 0);
    run_instr(0, 0, CMP_EQ, 0, 0, 32'h10, 32'h200, 9, 1, 5, 0, 0);
    run_instr(1, 0, CMP_EQ, 5, 5, 32'h8, 32'h40, 0, 1, 0, 2, 0);
    run_instr(0, 0, CMP_EQ, 0, 0, 32'h30, 32'h300, 4, 1, 0, 0, 0);
    @(negedge clk);
    issue_valid = 1; flush = 1;
    tick();
    issue_valid = 0; flush = 0;
    #1 chk("flush_beats_issue", busy, 0);
    @(negedge clk);
    issue_valid = 1; PC = 32'h500; imm = 4; rd = 2; is_branch = 0; JALR = 0;
    tick();
    issue_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1 chk("midrst_idle", busy, 0);
    chk("midrst_wbv", wb_valid, 0);
    @(negedge clk);
    issue_valid = 1; PC = 32'h600; imm = 8; rd = 3;
    tick();
    issue_valid = 0;
    for (int w = 0; w < 15; w++) begin
      tick();
      #1 chk("wd_wait_busy", busy, 1);
    end
`ifdef JUMP_WATCHDOG_EN
    tick();
    #1 chk("wd_idle", busy, 0);
    chk("wd_err", wdog_err, 1);
    chk("wd_nored", redirect_valid, 0);
    chk("wd_nowb", wb_valid, 0);
    @(negedge clk);
    rst = 1;
    tick();
    rst = 0;
    #1 chk("wd_rst_clear", wdog_err, 0);
`else
    repeat (5) tick();
    #1 chk("nowd_still_wait", busy, 1);
    chk("nowd_err", wdog_err, 0);
    @(negedge clk);
    flush = 1;
    tick();
    flush = 0;
    #1 chk("nowd_flush_idle", busy, 0);
`endif
    for (int n = 0; n < 200; n++) begin
      bit isb, jalr;
      logic [31:0] a, b;
      int lat, fl_at, fl_k, stall;
      isb = 1'($urandom);
      jalr = !isb && 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : (1'($urandom) ? $urandom : a ^ 32'h8000_0000);
      lat = $urandom_range(1, 4);
      stall = $urandom_range(0, 3);
      fl_at = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
      fl_k = fl_at == 2 ? $urandom_range(0, lat - 1) : $urandom_range(0, stall);
      run_instr(isb, jalr, ccs[$urandom_range(0, 5)], a, b, $urandom, $urandom,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), lat, stall, fl_at, fl_k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
